alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; power of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from in1[SHW-1:0].
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low; the block uses one clock, clk.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-007 SHALL have port in1, in2  input  WIDTH  operands.
REQ-008 SHALL have port ALUCtl  input  5  operation code.
REQ-009 SHALL have port Sign  input  1  signed compare/multiply/divide select.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-012 SHALL have port out_lo  output  WIDTH  primary result / product low / quotient.
REQ-013 SHALL have port out_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
REQ-014 SHALL have port zero  output  1  out_lo == 0.
REQ-015 SHALL have port div0  output  1  result came from a divide with in2 == 0.

Function
REQ-016 Single-cycle codes SHALL be: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00111 SLT (Sign: signed, else unsigned, result 0/1 zero-extended), 01100 NOR, 01101 XOR, 10000 SLL in2 by in1[SHW-1:0], 11000 SRL, 11001 SRA.
REQ-017 Multi-cycle codes SHALL be: 00011 MUL (2*WIDTH product into {out_hi,out_lo}), 00100 DIV (quotient out_lo, remainder out_hi); Sign selects signed.
REQ-018 Any other code SHALL produce out_lo = out_hi = 0 with single-cycle latency.
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-021 Single-cycle op accepted at edge k SHALL register result and enter DONE, out_valid high after edge k.
REQ-022 MUL/DIV accepted at edge k SHALL enter BUSY, iterate one bit per cycle (shift-add multiply, restoring divide on magnitudes), enter DONE with out_valid high after edge k+WIDTH.
REQ-023 Signed MUL/DIV SHALL negate magnitudes at completion; remainder sign follows dividend, quotient truncates toward zero.
REQ-024 DIV with in2 == 0 SHALL give out_lo = all ones, out_hi = in1, div0 = 1, still WIDTH cycles.
REQ-025 Signed DIV of most-negative by -1 SHALL give out_lo = most-negative, out_hi = 0.
REQ-026 In DONE, outputs SHALL hold stable while out_ready is low.
REQ-027 DONE with out_ready high and no new request SHALL return to IDLE, out_valid low next cycle.
REQ-028 DONE with out_ready and in_valid both high SHALL accept the new op in the same edge (back-to-back, no bubble).
REQ-029 In BUSY, in_valid SHALL be ignored and in_ready low; operands latched at acceptance, later input changes have no effect.
REQ-030 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, out_valid 0, out_lo 0, out_hi 0, div0 0, iteration counter 0.
REQ-032 Reset asserted during BUSY or DONE SHALL abort the operation; result discarded, no out_valid after release.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-034 Op-code constants and FSM state encodings SHALL live in shared package alu_pkg.
REQ-035 The iterative multiply/divide datapath SHALL be sub-module muldiv_iter (start, busy, done, signed handling); alu_muldiv holds FSM, single-cycle ops and handshake.

Verification (WIDTH=32)
REQ-036 ADD in1=FFFFFFFF, in2=1 -> out_valid after 1 edge, out_lo=0, zero=1, out_hi=0.
REQ-037 SRA in1=4, in2=80000000 -> out_lo=F8000000; SLT Sign=1 in1=FFFFFFFF, in2=1 -> 1; Sign=0 -> 0.
REQ-038 MUL Sign=1 in1=FFFFFFFE (-2), in2=3 -> after 32 edges out_hi=FFFFFFFF, out_lo=FFFFFFFA.
REQ-039 DIV Sign=1 in1=FFFFFFF9 (-7), in2=2 -> out_lo=FFFFFFFD, out_hi=FFFFFFFF; DIV in2=0 -> out_lo=FFFFFFFF, out_hi=in1, div0=1.
REQ-040 out_ready held low 5 cycles in DONE -> outputs stable, in_ready low; then out_ready high with new in_valid -> accepted same edge.
REQ-041 reset_n pulsed low at BUSY cycle 10 -> out_valid 0 immediately, never asserted for aborted op, in_ready 1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op-codes, FSM state encoding and helpers for alu_muldiv
//  Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [4:0] c_OP_AND = 5'b00000;
    localparam logic [4:0] c_OP_OR  = 5'b00001;
    localparam logic [4:0] c_OP_ADD = 5'b00010;
    localparam logic [4:0] c_OP_MUL = 5'b00011;
    localparam logic [4:0] c_OP_DIV = 5'b00100;
    localparam logic [4:0] c_OP_SUB = 5'b00110;
    localparam logic [4:0] c_OP_SLT = 5'b00111;
    localparam logic [4:0] c_OP_NOR = 5'b01100;
    localparam logic [4:0] c_OP_XOR = 5'b01101;
    localparam logic [4:0] c_OP_SLL = 5'b10000;
    localparam logic [4:0] c_OP_SRL = 5'b11000;
    localparam logic [4:0] c_OP_SRA = 5'b11001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [4:0] op);
        return (op == c_OP_MUL) || (op == c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Bit-serial shift-add multiplier / restoring divider
//  Revision    : 1.0
// ============================================================================
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div0
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;

    // The core always works on unsigned magnitudes; signs are restored at the end.
    assign w_a_mag = (sign && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (sign && b[WIDTH-1]) ? -b : b;

    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    // Only used when w_ge holds, so the true difference always fits WIDTH bits.
    assign w_sub   = w_shift[WIDTH-1:0] - r_b;
    assign w_last  = r_busy && (r_cnt == c_LAST);

    always_comb begin
        w_hi_n = w_add[WIDTH:1];
        w_lo_n = {w_add[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_hi_n = w_ge ? w_sub : w_shift[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_b      <= w_b_mag;
            r_is_div <= is_div;
            r_neg_q  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= sign & a[WIDTH-1];
            r_div0   <= is_div && (b == '0);
        end else if (r_busy) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Results are presented combinationally from the final iteration so the
    // caller can capture them on the same edge that completes the last bit.
    always_comb begin
        w_prod = {w_hi_n, w_lo_n};
        if (r_neg_q) begin
            w_prod = -{w_hi_n, w_lo_n};
        end
        res_lo = w_prod[WIDTH-1:0];
        res_hi = w_prod[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            res_lo = r_div0  ? '1 : (r_neg_q ? -w_lo_n : w_lo_n);
            // Divide-by-zero remainder is |a| with a's sign restored, i.e. a itself.
            res_hi = r_neg_r ? -w_hi_n : w_hi_n;
        end
    end

    assign busy = r_busy;
    assign done = w_last;
    assign div0 = r_div0;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Handshaked ALU with single-cycle ops and iterative MUL/DIV
//  Revision    : 1.0
// ============================================================================
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       ALUCtl,
    input  logic             Sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             div0
);

    state_t             r_state;
    state_t             w_state_n;
    logic [WIDTH-1:0]   r_out_lo;
    logic [WIDTH-1:0]   r_out_hi;
    logic               r_div0;

    logic               w_accept;
    logic               w_iter;
    logic               w_lt;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_single;
    logic               w_md_busy;
    logic               w_md_done;
    logic [WIDTH-1:0]   w_md_lo;
    logic [WIDTH-1:0]   w_md_hi;
    logic               w_md_div0;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_iter    = is_iter_op(ALUCtl);
    assign w_shamt   = in1[SHW-1:0];
    assign w_lt      = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        w_single = '0;
        case (ALUCtl)
            c_OP_AND: w_single = in1 & in2;
            c_OP_OR:  w_single = in1 | in2;
            c_OP_ADD: w_single = in1 + in2;
            c_OP_SUB: w_single = in1 - in2;
            c_OP_SLT: w_single = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_NOR: w_single = ~(in1 | in2);
            c_OP_XOR: w_single = in1 ^ in2;
            c_OP_SLL: w_single = in2 << w_shamt;
            c_OP_SRL: w_single = in2 >> w_shamt;
            c_OP_SRA: w_single = $unsigned($signed(in2) >>> w_shamt);
            default:  w_single = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_accept && w_iter),
        .is_div  (ALUCtl == c_OP_DIV),
        .sign    (Sign),
        .a       (in1),
        .b       (in2),
        .busy    (w_md_busy),
        .done    (w_md_done),
        .res_lo  (w_md_lo),
        .res_hi  (w_md_hi),
        .div0    (w_md_div0)
    );

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_n = w_iter ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_md_done) begin
                    w_state_n = ST_DONE;
                end else if (!w_md_busy) begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_n = w_iter ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_out_lo <= '0;
            r_out_hi <= '0;
            r_div0   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_accept && !w_iter) begin
                r_out_lo <= w_single;
                r_out_hi <= '0;
                r_div0   <= 1'b0;
            end else if ((r_state == ST_BUSY) && w_md_done) begin
                r_out_lo <= w_md_lo;
                r_out_hi <= w_md_hi;
                r_div0   <= w_md_div0;
            end
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign out_lo    = r_out_lo;
    assign out_hi    = r_out_hi;
    assign zero      = (r_out_lo == '0);
    assign div0      = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Directed and randomized self-checking bench for alu_muldiv
//  Revision    : 1.0
// ============================================================================
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         Sign      = 1'b0;
    logic [W-1:0] in1       = '0;
    logic [W-1:0] in2       = '0;
    logic [4:0]   ALUCtl    = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_lo;
    logic [W-1:0] out_hi;
    logic         zero;
    logic         div0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] e_lo;
    logic [W-1:0] e_hi;
    logic         e_div0;
    int           e_lat;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .ALUCtl    (ALUCtl),
        .Sign      (Sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lo    (out_lo),
        .out_hi    (out_hi),
        .zero      (zero),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference behaviour in plain integer arithmetic: {div0, hi, lo}.
    function automatic logic [2*W:0] ref_op(input logic [4:0] op, input logic s,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]   lo;
        logic [W-1:0]   hi;
        logic           d0;
        longint         sa;
        longint         sb;
        logic [2*W-1:0] p;
        logic [4:0]     sh;
        lo = '0; hi = '0; d0 = 1'b0; p = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = a[4:0];
        case (op)
            5'b00000: lo = a & b;
            5'b00001: lo = a | b;
            5'b00010: lo = a + b;
            5'b00110: lo = a - b;
            5'b00111: lo = s ? W'(sa < sb) : W'(a < b);
            5'b01100: lo = ~(a | b);
            5'b01101: lo = a ^ b;
            5'b10000: lo = b << sh;
            5'b11000: lo = b >> sh;
            5'b11001: lo = W'(sb >>> sh);
            5'b00011: begin
                if (s) p = 64'(sa * sb);
                else   p = {32'b0, a} * {32'b0, b};
                lo = p[W-1:0];
                hi = p[2*W-1:W];
            end
            5'b00100: begin
                if (b == '0) begin
                    lo = '1; hi = a; d0 = 1'b1;
                end else if (s) begin
                    lo = W'(sa / sb);
                    hi = W'(sa % sb);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin lo = '0; hi = '0; end
        endcase
        return {d0, hi, lo};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Presents an op at the next falling edge and lets it be accepted.
    task automatic start_op(input logic [4:0] op, input logic s,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        ALUCtl    = op;
        Sign      = s;
        in1       = a;
        in2       = b;
        out_ready = 1'b1;
        #1;
        chk("in_ready_at_request", W'(in_ready), W'(1));
        {e_div0, e_hi, e_lo} = ref_op(op, s, a, b);
        e_lat = (op == 5'b00011 || op == 5'b00100) ? W : 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = $urandom;
        in2       = $urandom;
        ALUCtl    = 5'($urandom);
        Sign      = 1'($urandom);
    endtask

    // Counts edges after acceptance while hammering the inputs with junk.
    task automatic wait_result(input string tag);
        int   lat;
        logic busy_rdy;
        lat = 0;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 4 * W) begin
            busy_rdy = busy_rdy | in_ready;
            in_valid = 1'b1;
            in1      = $urandom;
            in2      = $urandom;
            ALUCtl   = 5'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_valid"},      W'(out_valid), W'(1));
        chk({tag, "_latency"},    W'(lat),       W'(e_lat));
        chk({tag, "_lo"},         out_lo,        e_lo);
        chk({tag, "_hi"},         out_hi,        e_hi);
        chk({tag, "_zero"},       W'(zero),      W'(e_lo == '0));
        chk({tag, "_div0"},       W'(div0),      W'(e_div0));
        chk({tag, "_busy_ready"}, W'(busy_rdy),  W'(0));
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_ready", W'(in_ready),  W'(0));
            chk("hold_lo",    out_lo,        e_lo);
            chk("hold_hi",    out_hi,        e_hi);
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", W'(out_valid), W'(0));
        chk("release_ready", W'(in_ready),  W'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        logic seen_valid;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", W'(out_valid), W'(0));
        chk("rst_lo",    out_lo,        W'(0));
        chk("rst_hi",    out_hi,        W'(0));
        chk("rst_div0",  W'(div0),      W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_release_ready", W'(in_ready), W'(1));

        start_op(5'b00010, 1'b0, 32'hFFFF_FFFF, 32'h1);          wait_result("add_wrap"); release_out();
        start_op(5'b11001, 1'b0, 32'h4, 32'h8000_0000);          wait_result("sra");      release_out();
        start_op(5'b00111, 1'b1, 32'hFFFF_FFFF, 32'h1);          wait_result("slt_s");    release_out();
        start_op(5'b00111, 1'b0, 32'hFFFF_FFFF, 32'h1);          wait_result("slt_u");    release_out();
        start_op(5'b00011, 1'b1, 32'hFFFF_FFFE, 32'h3);          wait_result("mul_s");    release_out();
        start_op(5'b00100, 1'b1, 32'hFFFF_FFF9, 32'h2);          wait_result("div_s");    release_out();
        start_op(5'b00100, 1'b1, 32'h8765_4321, 32'h0);          wait_result("div_zero"); release_out();
        start_op(5'b00100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_result("div_ovf");  release_out();
        start_op(5'b11111, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);  wait_result("bad_op");   release_out();

        // Stalled consumer, then back-to-back accepts out of DONE.
        start_op(5'b00011, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);  wait_result("mul_u");
        hold(5);
        start_op(5'b01101, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);  wait_result("b2b_xor");
        start_op(5'b00100, 1'b0, 32'hFFFF_FFFF, 32'h10);         wait_result("b2b_div");
        release_out();

        // Reset in the middle of an iterative op.
        start_op(5'b00011, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_valid", W'(out_valid), W'(0));
        chk("abort_lo",    out_lo,        W'(0));
        chk("abort_hi",    out_hi,        W'(0));
        chk("abort_div0",  W'(div0),      W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("abort_release_ready", W'(in_ready), W'(1));
        seen_valid = 1'b0;
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        chk("abort_no_valid", W'(seen_valid), W'(0));

        for (int i = 0; i < 30; i++) begin
            logic [4:0] op;
            case ($urandom_range(0, 13))
                0:  op = 5'b00000;
                1:  op = 5'b00001;
                2:  op = 5'b00010;
                3:  op = 5'b00110;
                4:  op = 5'b00111;
                5:  op = 5'b01100;
                6:  op = 5'b01101;
                7:  op = 5'b10000;
                8:  op = 5'b11000;
                9:  op = 5'b11001;
                10: op = 5'b00011;
                11: op = 5'b00100;
                12: op = 5'b00101;
                default: op = 5'b10101;
            endcase
            start_op(op, 1'($urandom), pick_operand(), pick_operand());
            wait_result("rnd");
            hold($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                release_out();
            end
        end
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
